// File: rtl/alu_op_sequencer_if.sv
// Handshake bundle between the instruction decoder, the opcode sequencer and the ALU.
// The master modport is the sequencer; the slave modport is the decoder/ALU side.
interface alu_op_sequencer_if #(
    parameter int COUNT_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [3+COUNT_W:0] in_instr;
    logic               alu_valid;
    logic               alu_ready;
    logic [3:0]         alu_op;
    logic               alu_last;

    modport master (
        input  in_valid,
        input  in_instr,
        output in_ready,
        output alu_valid,
        input  alu_ready,
        output alu_op,
        output alu_last
    );

    modport slave (
        output in_valid,
        output in_instr,
        input  in_ready,
        input  alu_valid,
        output alu_ready,
        input  alu_op,
        input  alu_last
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Expands decoder instruction words into ALU opcode sequences: direct ops,
// repeated left shifts and add/shift multiply steps.
module alu_op_sequencer #(
    parameter int COUNT_W = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               flush_i,
    alu_op_sequencer_if.master bus,
    output logic               busy_o,
    output logic               err_illegal_o
);
    localparam logic [3:0] K_ADD        = 4'h5;
    localparam logic [3:0] K_SHIFT_LEFT = 4'h1;
    localparam logic [3:0] OP_REP_SHL   = 4'hD;
    localparam logic [3:0] OP_MUL_STEP  = 4'hE;
    localparam logic [3:0] OP_ILLEGAL   = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        MUL_ADD,
        MUL_SHL
    } state_e;

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] rem_q, rem_d;
    logic [3:0]         op_q, op_d;
    logic               err_q, err_d;

    logic [3:0]         op_field;
    logic [COUNT_W-1:0] imm;
    logic               accept;
    logic               handshake;

    assign op_field  = bus.in_instr[3+COUNT_W -: 4];
    assign imm       = bus.in_instr[COUNT_W-1:0];
    assign accept    = bus.in_valid && bus.in_ready;
    assign handshake = bus.alu_valid && bus.alu_ready;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        op_d    = op_q;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // imm-1 wraps to all ones for imm==0, i.e. 2^COUNT_W iterations
                    if (op_field == OP_ILLEGAL) begin
                        err_d = 1'b1;
                    end else if (op_field == OP_MUL_STEP) begin
                        state_d = MUL_ADD;
                        op_d    = K_ADD;
                        rem_d   = imm - COUNT_W'(1);
                    end else if (op_field == OP_REP_SHL) begin
                        state_d = ISSUE;
                        op_d    = K_SHIFT_LEFT;
                        rem_d   = imm - COUNT_W'(1);
                    end else begin
                        state_d = ISSUE;
                        op_d    = op_field;
                        rem_d   = '0;
                    end
                end
            end
            ISSUE: begin
                if (handshake) begin
                    if (rem_q == '0) begin
                        state_d = IDLE;
                        op_d    = 4'h0;
                    end else begin
                        rem_d = rem_q - COUNT_W'(1);
                    end
                end
            end
            MUL_ADD: begin
                if (handshake) begin
                    state_d = MUL_SHL;
                    op_d    = K_SHIFT_LEFT;
                end
            end
            MUL_SHL: begin
                if (handshake) begin
                    if (rem_q == '0) begin
                        state_d = IDLE;
                        op_d    = 4'h0;
                    end else begin
                        state_d = MUL_ADD;
                        op_d    = K_ADD;
                        rem_d   = rem_q - COUNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                op_d    = 4'h0;
                rem_d   = '0;
            end
        endcase

        // Flush overrides any handshake taken in the same cycle.
        if (flush_i) begin
            state_d = IDLE;
            rem_d   = '0;
            op_d    = 4'h0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            op_q    <= 4'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !flush_i;
    assign bus.alu_valid = (state_q != IDLE);
    assign bus.alu_op    = op_q;
    assign bus.alu_last  = ((state_q == ISSUE) || (state_q == MUL_SHL)) && (rem_q == '0);
    assign busy_o        = (state_q != IDLE);
    assign err_illegal_o = err_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized and directed bench for alu_op_sequencer against a queue-based
// model of the expected opcode stream.
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic reset, flush;
    logic busy, err_illegal;

    alu_op_sequencer_if #(.COUNT_W(4)) bus ();

    alu_op_sequencer #(.COUNT_W(4)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .flush_i       (flush),
        .bus           (bus.master),
        .busy_o        (busy),
        .err_illegal_o (err_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] op;
        logic       last;
    } ent_t;

    ent_t mq[$];     // opcodes still owed to the ALU, head is on the bus
    ent_t hlog[$];   // handshakes actually observed
    logic err_exp = 1'b0;
    bit   started = 1'b0;
    int   total = 0, bad = 0;
    int   err_cnt = 0, busy_cnt = 0;
    int   mode = 0;  // 0: ready high, 1: toggle, 2: random

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void push_instr(input logic [7:0] ins);
        int n;
        n = (ins[3:0] == 4'h0) ? 16 : int'(ins[3:0]);
        if (ins[7:4] <= 4'hC) begin
            mq.push_back('{op: ins[7:4], last: 1'b1});
        end else if (ins[7:4] == 4'hD) begin
            for (int i = 0; i < n; i++) mq.push_back('{op: 4'h1, last: (i == n - 1)});
        end else if (ins[7:4] == 4'hE) begin
            for (int i = 0; i < n; i++) begin
                mq.push_back('{op: 4'h5, last: 1'b0});
                mq.push_back('{op: 4'h1, last: (i == n - 1)});
            end
        end else begin
            err_exp = 1'b1;
        end
    endfunction

    // Model: advances on every rising edge from the bench-driven inputs only.
    initial forever begin
        bit acc, hs;
        @(posedge clk);
        started = 1'b1;
        if (reset || flush) begin
            mq.delete();
            err_exp = 1'b0;
        end else begin
            acc = bus.in_valid && (mq.size() == 0);
            hs  = (mq.size() > 0) && bus.alu_ready;
            err_exp = 1'b0;
            if (hs) void'(mq.pop_front());
            if (acc) push_instr(bus.in_instr);
        end
    end

    // Compare process: checks every cycle, away from the rising edge.
    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("alu_valid", bus.alu_valid, mq.size() > 0);
            chk("busy", busy, mq.size() > 0);
            chk("in_ready", bus.in_ready, (mq.size() == 0) && !flush);
            chk("err_illegal", err_illegal, err_exp);
            if (mq.size() > 0) begin
                chk("alu_op", bus.alu_op, mq[0].op);
                chk("alu_last", bus.alu_last, mq[0].last);
            end
            if (bus.alu_valid && bus.alu_ready && !flush && !reset)
                hlog.push_back('{op: bus.alu_op, last: bus.alu_last});
            if (err_illegal) err_cnt++;
            if (busy) busy_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        case (mode)
            0:       bus.alu_ready = 1'b1;
            1:       bus.alu_ready = ~bus.alu_ready;
            default: bus.alu_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic clear_obs();
        hlog.delete();
        err_cnt  = 0;
        busy_cnt = 0;
    endtask

    task automatic send(input logic [7:0] ins);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.in_ready;
            step();
            n++;
        end
        bus.in_valid = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int max, input bit rand_flush);
        int n;
        n = 0;
        while (busy && n < max) begin
            flush = rand_flush && ($urandom_range(0, 39) == 0);
            step();
            n++;
        end
        flush = 1'b0;
        if (n >= max) chk("idle_timeout", 0, 1);
        step();
        step();
    endtask

    task automatic check_lasts(input string nm, input int n);
        chk({nm, "_count"}, hlog.size(), n);
        for (int i = 0; i < hlog.size(); i++)
            chk({nm, "_last"}, hlog[i].last, (i == n - 1));
    endtask

    task automatic abort_after3(input bit use_reset);
        int n;
        mode = 0;
        clear_obs();
        send(8'hD8);
        n = 0;
        while (hlog.size() < 3 && n < 50) begin
            step();
            n++;
        end
        if (use_reset) reset = 1'b1; else flush = 1'b1;
        step();
        chk("abort_hs", hlog.size(), 3);
        chk("abort_valid", bus.alu_valid, 0);
        chk("abort_busy", busy, 0);
        if (use_reset) begin
            chk("rst_op", bus.alu_op, 0);
            chk("rst_last", bus.alu_last, 0);
            chk("rst_err", err_illegal, 0);
            chk("rst_in_ready", bus.in_ready, 1);
        end else begin
            chk("flush_in_ready", bus.in_ready, 0);
        end
        reset = 1'b0;
        flush = 1'b0;
        #1;
        chk("abort_ready_after", bus.in_ready, 1);
        step();
        step();
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 8'h00;
        bus.alu_ready = 1'b1;
        step();
        step();
        chk("reset_op", bus.alu_op, 0);
        chk("reset_last", bus.alu_last, 0);
        chk("reset_in_ready", bus.in_ready, 1);
        reset = 1'b0;
        step();

        clear_obs();
        send(8'h5A);
        wait_idle(100, 1'b0);
        chk("d5a_op", hlog.size() > 0 ? hlog[0].op : 4'hx, 4'h5);
        check_lasts("d5a", 1);
        chk("d5a_busy", busy_cnt, 1);

        clear_obs();
        send(8'hD3);
        wait_idle(100, 1'b0);
        for (int i = 0; i < hlog.size(); i++) chk("d3_op", hlog[i].op, 4'h1);
        check_lasts("d3", 3);
        chk("d3_busy", busy_cnt, 3);

        mode = 1;
        bus.alu_ready = 1'b1;
        clear_obs();
        send(8'hE2);
        wait_idle(100, 1'b0);
        for (int i = 0; i < hlog.size(); i++) chk("e2_op", hlog[i].op, (i % 2 == 0) ? 4'h5 : 4'h1);
        check_lasts("e2", 4);

        mode = 0;
        clear_obs();
        send(8'hD0);
        wait_idle(200, 1'b0);
        check_lasts("d0", 16);
        clear_obs();
        send(8'hE0);
        wait_idle(200, 1'b0);
        check_lasts("e0", 32);

        clear_obs();
        send(8'hF7);
        wait_idle(100, 1'b0);
        chk("f7_hs", hlog.size(), 0);
        chk("f7_err", err_cnt, 1);
        chk("f7_busy", busy_cnt, 0);
        clear_obs();
        send(8'h2C);
        wait_idle(100, 1'b0);
        chk("after_f7_op", hlog.size() > 0 ? hlog[0].op : 4'hx, 4'h2);
        check_lasts("after_f7", 1);

        // Held-valid back-to-back direct ops: one opcode every other cycle.
        clear_obs();
        bus.in_valid = 1'b1;
        bus.in_instr = 8'h31;
        repeat (20) step();
        bus.in_valid = 1'b0;
        repeat (3) step();
        chk("b2b_hs", hlog.size(), 10);

        abort_after3(1'b0);
        abort_after3(1'b1);

        for (int k = 0; k < 40; k++) begin
            mode = int'($urandom_range(0, 2));
            send(8'($urandom_range(0, 255)));
            wait_idle(400, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
